ub_drain: RTL and testbench

UB_DRAIN -- requirements
Module: ub_drain

---
 rtl/tpu_pkg.sv | 17 +
 rtl/ub_drain.sv | 115 +++++++++++
 tb/tb_ub_drain.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default matrix geometry, data/address widths and the
// drain FSM state encoding.
package tpu_pkg;

   localparam int unsigned TPU_N      = 2;
   localparam int unsigned TPU_DATA_W = 8;
   localparam int unsigned TPU_ADDR_W = 13;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_SEND,
      ST_DONE
   } drain_state_t;

endpackage

// File: rtl/ub_drain.sv
// Unified-buffer drain: reads an N*N result matrix row-major from the unified
// buffer and streams it to the host over a valid/ready interface.
module ub_drain
   import tpu_pkg::*;
#(
   parameter int unsigned N      = TPU_N,
   parameter int unsigned DATA_W = TPU_DATA_W,
   parameter int unsigned ADDR_W = TPU_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   // One spare bit keeps the width legal for N=1.
   localparam int unsigned IDX_W = $clog2(N * N) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

   drain_state_t      r_state;
   drain_state_t      w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [ADDR_W-1:0] r_base;
   logic [DATA_W-1:0] r_out_data;
   logic              w_is_last;
   logic              w_handshake;

   assign w_is_last   = (r_idx == LAST_IDX);
   assign w_handshake = (r_state == ST_SEND) && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx      <= '0;
         r_base     <= '0;
         r_out_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_base <= base_addr;
                  r_idx  <= '0;
               end
            end
            ST_WAIT: r_out_data <= rd_data;
            ST_SEND: begin
               if (out_ready && !w_is_last) begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      rd_en       = 1'b0;
      rd_addr     = '0;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            rd_en       = 1'b1;
            // Address wraps naturally at ADDR_W bits.
            rd_addr     = r_base + ADDR_W'(r_idx);
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            w_state_nxt = ST_SEND;
         end
         ST_SEND: begin
            out_valid = 1'b1;
            out_last  = w_is_last;
            if (w_handshake) begin
               w_state_nxt = w_is_last ? ST_DONE : ST_READ;
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign out_data = r_out_data;

endmodule

// File: tb/tb_ub_drain.sv
// Scoreboard bench for ub_drain: stimulus pushes expected read addresses and
// stream elements; a negedge monitor pops and compares them.
module tb_ub_drain;

   localparam int unsigned N      = 2;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 13;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] ub [0:(1<<ADDR_W)-1];

   logic [ADDR_W-1:0] exp_addr_q [$];
   logic [DATA_W:0]   exp_elem_q [$];

   int n_cmp = 0;
   int n_err = 0;
   int hs_cnt = 0;
   int done_cnt = 0;

   ub_drain #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unified buffer model: one-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) rd_data <= ub[rd_addr];
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (rd_en) begin
            if (exp_addr_q.size() == 0) begin
               check("unexpected_rd_en", 1, 0);
            end else begin
               check("rd_addr", int'(rd_addr), int'(exp_addr_q.pop_front()));
            end
         end
         if (out_valid && out_ready) begin
            if (exp_elem_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               check("out_data_last", int'({out_last, out_data}), int'(exp_elem_q.pop_front()));
            end
            hs_cnt++;
         end
         if (done) done_cnt++;
      end
   end

   task automatic push_drain(input logic [ADDR_W-1:0] base);
      for (int i = 0; i < N*N; i++) begin
         logic [ADDR_W-1:0] a;
         a = base + ADDR_W'(i);
         exp_addr_q.push_back(a);
         exp_elem_q.push_back({(i == N*N-1), ub[a]});
      end
   endtask

   // Returns at posedge+1 of the READ cycle of element 0.
   task automatic kick(input logic [ADDR_W-1:0] base);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = base;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int target);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done_cnt >= target) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("done_timeout", int'(ok), 1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit seen;
      int d0;
      reset = 1'b0;
      start = 1'b0;
      base_addr = '0;
      out_ready = 1'b1;
      rd_data = '0;
      ub[13'h010] = 8'd5;  ub[13'h011] = 8'd7;  ub[13'h012] = 8'd11; ub[13'h013] = 8'd13;
      ub[13'h1FFF] = 8'd101; ub[13'h000] = 8'd102; ub[13'h001] = 8'd103; ub[13'h002] = 8'd104;
      ub[13'h020] = 8'd21; ub[13'h021] = 8'd22; ub[13'h022] = 8'd23; ub[13'h023] = 8'd24;
      ub[13'h100] = 8'd99; ub[13'h101] = 8'd98; ub[13'h102] = 8'd97; ub[13'h103] = 8'd96;

      // Reset state
      wait_cycles(3);
      check("reset_outputs", int'({rd_en, rd_addr, out_valid, out_data, out_last, busy, done}), 0);
      reset = 1'b1;
      wait_cycles(2);

      // Basic drain with latency checks
      push_drain(13'h010);
      kick(13'h010);
      @(negedge clk);
      check("lat_read_rd_en", int'({rd_en, out_valid, busy}), 3'b101);
      @(negedge clk);
      check("lat_wait", int'({rd_en, out_valid}), 0);
      @(negedge clk);
      check("lat_send_valid", int'(out_valid), 1);
      wait_done(1);
      wait_cycles(4);
      check("basic_done_count", done_cnt, 1);
      check("basic_idle", int'(busy), 0);

      // Backpressure on element 2
      push_drain(13'h010);
      kick(13'h010);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (hs_cnt >= 6) begin seen = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("bp_reach_elem2", int'(seen), 1);
      out_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin seen = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("bp_valid_seen", int'(seen), 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_hold", int'({out_valid, rd_en, out_data}), int'({1'b1, 1'b0, 8'd11}));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done(2);
      wait_cycles(3);

      // Address wrap
      push_drain(13'h1FFF);
      kick(13'h1FFF);
      wait_done(3);
      wait_cycles(3);

      // Start during SEND is ignored
      push_drain(13'h020);
      kick(13'h020);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin seen = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("ign_valid_seen", int'(seen), 1);
      start = 1'b1;
      base_addr = 13'h100;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = '0;
      wait_done(4);
      wait_cycles(10);
      check("ign_done_count", done_cnt, 4);
      check("ign_idle", int'(busy), 0);

      // Reset during WAIT of element 1
      d0 = hs_cnt;
      push_drain(13'h010);
      kick(13'h010);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (hs_cnt == d0 + 1) begin seen = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("rst_reach_elem1", int'(seen), 1);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("rst_outputs", int'({rd_en, rd_addr, out_valid, out_data, out_last, busy, done}), 0);
      exp_addr_q.delete();
      exp_elem_q.delete();
      wait_cycles(3);
      reset = 1'b1;
      wait_cycles(6);
      check("rst_no_done", done_cnt, 4);
      check("rst_idle", int'(busy), 0);
      push_drain(13'h010);
      kick(13'h010);
      wait_done(5);
      wait_cycles(3);

      // Back-to-back with start held high
      push_drain(13'h010);
      push_drain(13'h010);
      kick(13'h010);
      start = 1'b1;
      base_addr = 13'h010;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      check("b2b_done_seen", int'(seen), 1);
      @(negedge clk);
      check("b2b_idle_cycle", int'({busy, rd_en}), 0);
      @(negedge clk);
      check("b2b_rd_en_next", int'({busy, rd_en}), 3);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(7);
      wait_cycles(6);
      check("b2b_done_count", done_cnt, 7);

      check("addr_q_empty", exp_addr_q.size(), 0);
      check("elem_q_empty", exp_elem_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
